// File: rtl/jkc_pkg.sv
// Shared definitions for the JK sequencing counter.
//   state_t  : controller states IDLE / STEP / DONE
//   JK_*     : JK input-pair encodings, packed as {J,K}
//   jk_next  : next value of a single JK flip-flop for a given {J,K} pair
package jkc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  function automatic logic jk_next(input logic cur, input logic [1:0] jk);
    logic res;
    case (jk)
      JK_HOLD: res = cur;
      JK_CLR:  res = 1'b0;
      JK_SET:  res = 1'b1;
      JK_TGL:  res = ~cur;
      default: res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// JK excitation (inverse mapping): given the present and desired next value
// of each bit, produce the J/K pair that moves the flip-flop there. The
// don't-care entries are resolved to 0, so an unchanged bit gets J=K=0.
// Ports:
//   cur : present flip-flop values
//   nxt : desired next values
//   j   : J excitation (set where 0 -> 1)
//   k   : K excitation (clear where 1 -> 0)
module jk_excite #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  assign j = ~cur & nxt;
  assign k = cur & ~nxt;

endmodule

// File: rtl/jk_seq_counter.sv
// JK-flip-flop counter that steps q toward a latched target one count per
// cycle, then pulses done. The counter bits are JK flip-flops driven only by
// the J/K vectors produced by jk_excite.
// Optional feature: define JKC_DOWN_COUNT_EN to let the counter count down
// when the target is below q at acceptance (direction fixed for the whole
// operation). Without it the counter only counts up, wrapping through 0.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request an operation (sampled in IDLE only)
//   target : goal value, latched when start is accepted
//   hold   : freeze q for the cycle while stepping
//   q      : counter value
//   j_vec  : J excitation applied this cycle
//   k_vec  : K excitation applied this cycle
//   busy   : high while stepping
//   done   : one-cycle completion pulse
module jk_seq_counter
  import jkc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic             hold,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             busy,
  output logic             done
);

  state_t           state_r;
  state_t           state_nxt;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j_raw;
  logic [WIDTH-1:0] k_raw;
  logic [WIDTH-1:0] q_jk;
  logic             accept;
  logic             at_tgt;
  logic             step_en;

  assign accept = (state_r == IDLE) && start;
  assign at_tgt = (q_r == tgt_r);

`ifdef JKC_DOWN_COUNT_EN
  logic down_r;

  // q is stable in IDLE, so comparing against it at acceptance is the same
  // as comparing at the first STEP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      down_r <= 1'b0;
    end else if (accept) begin
      down_r <= (target < q_r);
    end
  end

  assign nxt = down_r ? (q_r - 1'b1) : (q_r + 1'b1);
`else
  assign nxt = q_r + 1'b1;
`endif

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .cur (q_r),
    .nxt (nxt),
    .j   (j_raw),
    .k   (k_raw)
  );

  // Excitation only reaches the flip-flops on a real step; gating with rst
  // keeps j/k at zero while reset is being applied.
  assign step_en = (state_r == STEP) && !hold && !at_tgt && !rst;
  assign j_vec   = step_en ? j_raw : '0;
  assign k_vec   = step_en ? k_raw : '0;

  always_comb begin
    q_jk = '0;
    for (int i = 0; i < WIDTH; i++) begin
      q_jk[i] = jk_next(q_r[i], {j_vec[i], k_vec[i]});
    end
  end

  // JK flip-flop bank
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else begin
      q_r <= q_jk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_r <= '0;
    end else if (accept) begin
      tgt_r <= target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // A held cycle freezes the whole step, including the move to DONE.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt = STEP;
      STEP:    if (!hold && at_tgt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign q    = q_r;
  assign busy = (state_r == STEP) && !rst;
  assign done = (state_r == DONE) && !rst;

endmodule

// File: tb/tb_jk_seq_counter.sv
module tb_jk_seq_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] target = 4'd0;
  logic       hold = 1'b0;
  logic [3:0] q;
  logic [3:0] j_vec;
  logic [3:0] k_vec;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [3:0] cur_q = 4'd0;

  typedef struct {
    logic       hold;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic [3:0] j;
    logic [3:0] k;
  } rec_t;

  rec_t sb[$];

  jk_seq_counter #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .hold   (hold),
    .q      (q),
    .j_vec  (j_vec),
    .k_vec  (k_vec),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Reference model: expected per-cycle outputs of one operation, starting
  // with the cycle after the start edge. Hold is active for cycles
  // [hs, hs+hl) counted from that first STEP cycle.
  task automatic push_op(input logic [3:0] q0, input logic [3:0] tgt,
                         input int hs, input int hl, input bit down,
                         output logic [3:0] q_end);
    logic [3:0] mq;
    logic [3:0] mn;
    rec_t r;
    int n;
    bit h;
    mq = q0;
    n = 0;
    while (n < 64) begin
      h = (n >= hs) && (n < hs + hl);
      mn = down ? mq - 4'd1 : mq + 4'd1;
      r.hold = h; r.q = mq; r.busy = 1'b1; r.done = 1'b0;
      r.j = 4'd0; r.k = 4'd0;
      if (!h && mq != tgt) begin
        for (int b = 0; b < 4; b++) begin
          case ({mq[b], mn[b]})
            2'b01: r.j[b] = 1'b1;
            2'b10: r.k[b] = 1'b1;
            default: ;
          endcase
        end
      end
      sb.push_back(r);
      if (!h) begin
        if (mq == tgt) break;
        mq = mn;
      end
      n++;
    end
    r.hold = 1'b0; r.q = mq; r.busy = 1'b0; r.done = 1'b1; r.j = 4'd0; r.k = 4'd0;
    sb.push_back(r);
    r.done = 1'b0;
    sb.push_back(r);
    q_end = mq;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q, busy, done, j_vec, k_vec} !== {4'd0, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_during got q=%0d busy=%0b done=%0b j=%b k=%b want all zero",
               q, busy, done, j_vec, k_vec);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({q, busy, done, j_vec, k_vec} !== {4'd0, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_after got q=%0d busy=%0b done=%0b j=%b k=%b want all zero",
               q, busy, done, j_vec, k_vec);
    end
    cur_q = 4'd0;
  endtask

  task automatic test_basic;
    rec_t r;
    int busy_n;
    int done_n;
    int cyc;
    busy_n = 0; done_n = 0; cyc = 0;
    @(posedge clk); #1;
    start = 1'b1; target = 4'd5;
    push_op(cur_q, 4'd5, 99, 0, 1'b0, cur_q);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(posedge clk); #1;
      start = 1'b0; hold = r.hold; target = 4'd12;
      #1;
      busy_n += busy; done_n += done;
      checks++;
      if ({q, busy, done, j_vec, k_vec} !== {r.q, r.busy, r.done, r.j, r.k}) begin
        errors++;
        $display("FAIL basic cyc %0d got q=%0d b=%0b d=%0b j=%b k=%b want q=%0d b=%0b d=%0b j=%b k=%b",
                 cyc, q, busy, done, j_vec, k_vec, r.q, r.busy, r.done, r.j, r.k);
      end
      cyc++;
    end
    checks++;
    if (busy_n != 6) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d want 6", busy_n);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL basic_done_pulses got %0d want 1", done_n);
    end
    @(posedge clk); #2;
    checks++;
    if (q !== 4'd5) begin
      errors++;
      $display("FAIL basic_q_holds got %0d want 5", q);
    end
  endtask

  task automatic test_wrap;
    rec_t r;
    int cyc;
    int seen;
    // reach 14 first, then ask for 1: count up through 15 and 0
    for (int op = 0; op < 2; op++) begin
      logic [3:0] t;
      t = (op == 0) ? 4'd14 : 4'd1;
      cyc = 0; seen = 0;
      @(posedge clk); #1;
      start = 1'b1; target = t;
      push_op(cur_q, t, 99, 0, 1'b0, cur_q);
      while (sb.size() > 0) begin
        r = sb.pop_front();
        @(posedge clk); #1;
        start = 1'b0; hold = r.hold;
        #1;
        checks++;
        if ({q, busy, done, j_vec, k_vec} !== {r.q, r.busy, r.done, r.j, r.k}) begin
          errors++;
          $display("FAIL wrap op%0d cyc %0d got q=%0d b=%0b d=%0b j=%b k=%b want q=%0d b=%0b d=%0b j=%b k=%b",
                   op, cyc, q, busy, done, j_vec, k_vec, r.q, r.busy, r.done, r.j, r.k);
        end
        if (op == 1 && r.busy && r.q == 4'd15) begin
          seen++;
          checks++;
          if (j_vec !== 4'b0000 || k_vec !== 4'b1111) begin
            errors++;
            $display("FAIL wrap_15_to_0 got j=%b k=%b want j=0000 k=1111", j_vec, k_vec);
          end
        end
        cyc++;
      end
      if (op == 1) begin
        checks++;
        if (seen != 1 || q !== 4'd1) begin
          errors++;
          $display("FAIL wrap_end got q=%0d seen15=%0d want q=1 seen15=1", q, seen);
        end
      end
    end
  endtask

  task automatic test_down;
    rec_t r;
    int cyc;
    int busy_n;
    // reach 9 counting up, then ask for 6: count down 8,7,6
    for (int op = 0; op < 2; op++) begin
      logic [3:0] t;
      t = (op == 0) ? 4'd9 : 4'd6;
      cyc = 0; busy_n = 0;
      @(posedge clk); #1;
      start = 1'b1; target = t;
      push_op(cur_q, t, 99, 0, (t < cur_q), cur_q);
      while (sb.size() > 0) begin
        r = sb.pop_front();
        @(posedge clk); #1;
        start = 1'b0; hold = r.hold;
        #1;
        busy_n += busy;
        checks++;
        if ({q, busy, done, j_vec, k_vec} !== {r.q, r.busy, r.done, r.j, r.k}) begin
          errors++;
          $display("FAIL down op%0d cyc %0d got q=%0d b=%0b d=%0b j=%b k=%b want q=%0d b=%0b d=%0b j=%b k=%b",
                   op, cyc, q, busy, done, j_vec, k_vec, r.q, r.busy, r.done, r.j, r.k);
        end
        cyc++;
      end
      if (op == 1) begin
        checks++;
        if (busy_n != 4 || q !== 4'd6) begin
          errors++;
          $display("FAIL down_end got busy_cycles=%0d q=%0d want 4 and 6", busy_n, q);
        end
      end
    end
  endtask

  task automatic test_hold;
    rec_t r;
    int cyc;
    int done_at;
    int busy_n;
    cyc = 0; done_at = -1; busy_n = 0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    cur_q = 4'd0;
    @(posedge clk); #1;
    start = 1'b1; target = 4'd3;
    push_op(cur_q, 4'd3, 1, 2, 1'b0, cur_q);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(posedge clk); #1;
      start = 1'b0; hold = r.hold;
      #1;
      busy_n += busy;
      if (done && done_at < 0) done_at = cyc;
      checks++;
      if ({q, busy, done, j_vec, k_vec} !== {r.q, r.busy, r.done, r.j, r.k}) begin
        errors++;
        $display("FAIL hold cyc %0d got q=%0d b=%0b d=%0b j=%b k=%b want q=%0d b=%0b d=%0b j=%b k=%b",
                 cyc, q, busy, done, j_vec, k_vec, r.q, r.busy, r.done, r.j, r.k);
      end
      cyc++;
    end
    hold = 1'b0;
    checks++;
    if (done_at != 6 || busy_n != 6) begin
      errors++;
      $display("FAIL hold_latency got done_at=%0d busy=%0d want 6 and 6", done_at, busy_n);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; target = 4'd7;
    @(posedge clk); #1;
    start = 1'b1; target = 4'd3;     // ignored while busy
    #1;
    checks++;
    if (busy !== 1'b1 || q !== 4'd0) begin
      errors++;
      $display("FAIL mid_started got busy=%0b q=%0d want 1 and 0", busy, q);
    end
    n = 0;
    while (q !== 4'd2 && n < 10) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      n++;
    end
    checks++;
    if (q !== 4'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach_2 got q=%0d busy=%0b after %0d cycles want q=2 busy=1", q, busy, n);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, j_vec, k_vec} !== {1'b0, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL mid_during_rst got b=%0b d=%0b j=%b k=%b want zeros", busy, done, j_vec, k_vec);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({q, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_after_rst got q=%0d b=%0b d=%0b want 0 0 0", q, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      checks++;
      if ({q, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL mid_idle cyc %0d got q=%0d b=%0b d=%0b want 0 0 0", i, q, busy, done);
      end
    end
    cur_q = 4'd0;
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef JKC_DOWN_COUNT_EN
    test_down();
`else
    test_wrap();
`endif
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
